llc_plru_engine: RTL and testbench

Parametrised tree pseudo-LRU replacement engine for the last-level cache. It holds ASSOCIATIVITY-1 PLRU bits per set for NUM_SETS sets. On request it performs one of four operations: marks ways most-recently-used, returns victims (invalid ways preferred), or sweeps all state clear. It sits beside the LLC tag/MESI array. The LLC controller issues TOUCH on every hit, ALLOC on every miss fill, and CLEAR for trace op 8.

---
 rtl/llc_plru_engine.sv | 177 +++++++++++++++++
 tb/tb_llc_plru_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/llc_plru_engine.sv
// Tree pseudo-LRU replacement engine for the LLC: TOUCH/VICTIM/ALLOC in one cycle, CLEAR sweeps one set per cycle.
// Responses are registered one cycle after accept; requests stall (req_ready low) only while a sweep runs.
module llc_plru_engine #(
  parameter int NUM_SETS      = 16384,
  parameter int ASSOCIATIVITY = 8,
  parameter int SET_BITS      = $clog2(NUM_SETS),
  parameter int WAY_BITS      = $clog2(ASSOCIATIVITY)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [SET_BITS-1:0]      req_set,
  input  logic [WAY_BITS-1:0]      req_way,
  input  logic [ASSOCIATIVITY-1:0] valid_mask,
  output logic                     rsp_valid,
  output logic [WAY_BITS-1:0]      rsp_way,
  output logic                     rsp_from_invalid,
  output logic                     busy
);

  localparam int NODES = ASSOCIATIVITY - 1;
  localparam logic [1:0] OP_TOUCH  = 2'd0;
  localparam logic [1:0] OP_VICTIM = 2'd1;
  localparam logic [1:0] OP_ALLOC  = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  typedef logic [NODES-1:0] tree_t;
  typedef enum logic { ST_IDLE = 1'b0, ST_SWEEP = 1'b1 } state_t;

  // Heap walk: node n has children 2n+1 (left) and 2n+2 (right); leaves start at index NODES.
  function automatic logic [WAY_BITS-1:0] plru_victim(input tree_t t);
    int node;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      node = 2 * node + ((((t >> node) & tree_t'(1)) != '0) ? 2 : 1);
    end
    return WAY_BITS'(node - NODES);
  endfunction

  function automatic tree_t plru_touch(input tree_t t, input logic [WAY_BITS-1:0] w);
    int    node;
    tree_t res;
    logic  go_right;
    res  = t;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      go_right = ((w >> (WAY_BITS - 1 - l)) & WAY_BITS'(1)) != '0;
      if (go_right) res = res & ~(tree_t'(1) << node);
      else          res = res |  (tree_t'(1) << node);
      node = 2 * node + (go_right ? 2 : 1);
    end
    return res;
  endfunction

  function automatic logic [WAY_BITS-1:0] first_invalid(input logic [ASSOCIATIVITY-1:0] m);
    logic [WAY_BITS-1:0] idx;
    idx = '0;
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
      if (((m >> i) & ASSOCIATIVITY'(1)) == '0) idx = WAY_BITS'(i);
    end
    return idx;
  endfunction

  tree_t tree_q [NUM_SETS];

  state_t              state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                clr_pend_q, clr_pend_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WAY_BITS-1:0] rsp_way_q, rsp_way_d;
  logic                rsp_inv_q, rsp_inv_d;

  logic                accept;
  logic                sweep_last;
  tree_t               cur_tree;
  logic [WAY_BITS-1:0] sel_way;
  logic                sel_inv;
  logic                tree_we;
  logic [SET_BITS-1:0] tree_wa;
  tree_t               tree_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_SWEEP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && req_op == OP_CLEAR) state_d = ST_SWEEP;
      ST_SWEEP: if (sweep_last) state_d = ST_IDLE;
      default:  state_d = ST_SWEEP;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_SWEEP);
    req_ready = !busy;
  end

  assign accept     = req_valid && req_ready;
  assign sweep_last = busy && (cnt_q == SET_BITS'(NUM_SETS - 1));

  always_comb begin
    cur_tree = tree_q[req_set];
    sel_way  = req_way;
    sel_inv  = 1'b0;
    if (req_op == OP_VICTIM || req_op == OP_ALLOC) begin
      if (!(&valid_mask)) begin
        sel_way = first_invalid(valid_mask);
        sel_inv = 1'b1;
      end else begin
        sel_way = plru_victim(cur_tree);
      end
    end

    tree_we = 1'b0;
    tree_wa = req_set;
    tree_d  = cur_tree;
    if (busy) begin
      tree_we = 1'b1;
      tree_wa = cnt_q;
      tree_d  = '0;
    end else if (accept && (req_op == OP_TOUCH || req_op == OP_ALLOC)) begin
      tree_we = 1'b1;
      tree_d  = plru_touch(cur_tree, sel_way);
    end

    cnt_d = busy ? cnt_q + SET_BITS'(1) : '0;

    // Only a CLEAR-initiated sweep reports completion; a reset sweep has no requester.
    clr_pend_d = clr_pend_q;
    if (accept && req_op == OP_CLEAR) clr_pend_d = 1'b1;
    else if (sweep_last)              clr_pend_d = 1'b0;

    rsp_valid_d = 1'b0;
    rsp_way_d   = rsp_way_q;
    rsp_inv_d   = rsp_inv_q;
    if (accept && req_op != OP_CLEAR) begin
      rsp_valid_d = 1'b1;
      rsp_way_d   = sel_way;
      rsp_inv_d   = sel_inv;
    end else if (sweep_last && clr_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_way_d   = '0;
      rsp_inv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      clr_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_inv_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      clr_pend_q  <= clr_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
      rsp_inv_q   <= rsp_inv_d;
    end
  end

  // PLRU storage is not reset directly; the reset-triggered sweep zeroes it.
  always_ff @(posedge clk) begin
    if (tree_we) tree_q[tree_wa] <= tree_d;
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_way          = rsp_way_q;
  assign rsp_from_invalid = rsp_inv_q;

endmodule

// File: tb/tb_llc_plru_engine.sv
// Bench for llc_plru_engine at 4 sets x 4 ways: directed scenarios plus random traffic against a per-set PLRU model.
module tb_llc_plru_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [1:0] req_set = 2'd0;
  logic [1:0] req_way = 2'd0;
  logic [3:0] valid_mask = 4'hF;
  logic       rsp_valid;
  logic [1:0] rsp_way;
  logic       rsp_from_invalid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model: each set's tree as three named pointers (root, left pair, right pair).
  int m_root [4];
  int m_l    [4];
  int m_r    [4];

  always #5 clk = ~clk;

  llc_plru_engine #(.NUM_SETS(4), .ASSOCIATIVITY(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_set          (req_set),
    .req_way          (req_way),
    .valid_mask       (valid_mask),
    .rsp_valid        (rsp_valid),
    .rsp_way          (rsp_way),
    .rsp_from_invalid (rsp_from_invalid),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int s = 0; s < 4; s++) begin
      m_root[s] = 0; m_l[s] = 0; m_r[s] = 0;
    end
  endfunction

  function automatic int m_plru(input int s);
    return (m_root[s] == 0) ? m_l[s] : 2 + m_r[s];
  endfunction

  function automatic void m_touch(input int s, input int w);
    m_root[s] = (w < 2) ? 1 : 0;
    if (w < 2) m_l[s] = (w == 0) ? 1 : 0;
    else       m_r[s] = (w == 2) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one non-CLEAR request and check its response in the following cycle.
  task automatic do_req(input int op, input int s, input int w, input logic [3:0] mask,
                        output int obs_way, output int obs_inv, output int waits);
    int ew, ei;
    req_valid  = 1'b1;
    req_op     = 2'(op);
    req_set    = 2'(s);
    req_way    = 2'(w);
    valid_mask = mask;
    waits = 0;
    while (!req_ready && waits < 50) begin
      step();
      waits++;
    end
    if (waits >= 50) check("req_ready_timeout", 32'(req_ready), 32'd1);
    if (op == 0) begin
      ew = w; ei = 0;
      m_touch(s, w);
    end else begin
      if (mask != 4'hF) begin
        ei = 1; ew = 0;
        for (int i = 3; i >= 0; i--) if (mask[i] == 1'b0) ew = i;
      end else begin
        ei = 0; ew = m_plru(s);
      end
      if (op == 2) m_touch(s, ew);
    end
    step();
    req_valid = 1'b0;
    check($sformatf("rsp_valid op%0d set%0d", op, s), 32'(rsp_valid), 32'd1);
    check($sformatf("rsp_way op%0d set%0d", op, s), 32'(rsp_way), 32'(ew));
    check($sformatf("rsp_inv op%0d set%0d", op, s), 32'(rsp_from_invalid), 32'(ei));
    obs_way = int'(rsp_way);
    obs_inv = int'(rsp_from_invalid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ow, oi, wt;
    logic [3:0] mk;
    m_clear();

    // Reset: values in the cycle after rst is sampled, then exactly 4 busy cycles.
    step();
    step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_way", 32'(rsp_way), 32'd0);
    check("rst_rsp_inv", 32'(rsp_from_invalid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_sweep_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("rst_sweep_notready%0d", i), 32'(req_ready), 32'd0);
      step();
    end
    check("rst_done_ready", 32'(req_ready), 32'd1);
    check("rst_done_busy", 32'(busy), 32'd0);

    do_req(1, 2, 0, 4'hF, ow, oi, wt);
    check("first_victim_way", 32'(ow), 32'd0);

    // Touch then victim on set 1; set 0 untouched.
    do_req(0, 1, 0, 4'hF, ow, oi, wt);
    do_req(1, 1, 0, 4'hF, ow, oi, wt);
    check("victim_after_touch0", 32'(ow), 32'd2);
    do_req(0, 1, 2, 4'hF, ow, oi, wt);
    do_req(1, 1, 0, 4'hF, ow, oi, wt);
    check("victim_after_touch2", 32'(ow), 32'd1);
    do_req(1, 0, 0, 4'hF, ow, oi, wt);
    check("set0_unaffected", 32'(ow), 32'd0);

    // Back-to-back ALLOCs on set 3.
    for (int i = 0; i < 4; i++) begin
      int exp_seq [4] = '{0, 2, 1, 3};
      do_req(2, 3, 0, 4'hF, ow, oi, wt);
      check($sformatf("alloc_seq%0d", i), 32'(ow), 32'(exp_seq[i]));
      check($sformatf("alloc_nostall%0d", i), 32'(wt), 32'd0);
    end

    // Invalid ways take priority over PLRU.
    do_req(1, 3, 0, 4'b1011, ow, oi, wt);
    check("inv_victim_way", 32'(ow), 32'd2);
    check("inv_victim_flag", 32'(oi), 32'd1);
    do_req(1, 3, 0, 4'hF, ow, oi, wt);
    do_req(2, 0, 0, 4'b0110, ow, oi, wt);
    check("inv_alloc_way", 32'(ow), 32'd0);
    check("inv_alloc_flag", 32'(oi), 32'd1);
    do_req(1, 0, 0, 4'hF, ow, oi, wt);
    check("after_inv_alloc", 32'(ow), 32'd2);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      mk = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      do_req(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), mk, ow, oi, wt);
    end

    // Dirty every set, leave a nonzero rsp_way, confirm it holds while idle.
    for (int s = 0; s < 4; s++) do_req(0, s, 0, 4'hF, ow, oi, wt);
    do_req(0, 0, 1, 4'hF, ow, oi, wt);
    step();
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_way_hold", 32'(rsp_way), 32'd1);

    // CLEAR: 4 busy cycles, then a single completion pulse with way 0.
    req_valid = 1'b1;
    req_op    = 2'd3;
    step();
    req_valid = 1'b0;
    m_clear();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clr_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("clr_norsp%0d", i), 32'(rsp_valid), 32'd0);
      step();
    end
    check("clr_done_ready", 32'(req_ready), 32'd1);
    check("clr_done_rsp_valid", 32'(rsp_valid), 32'd1);
    check("clr_done_rsp_way", 32'(rsp_way), 32'd0);
    check("clr_done_rsp_inv", 32'(rsp_from_invalid), 32'd0);
    step();
    check("clr_single_pulse", 32'(rsp_valid), 32'd0);
    for (int s = 0; s < 4; s++) begin
      do_req(1, s, 0, 4'hF, ow, oi, wt);
      check($sformatf("clr_victim_set%0d", s), 32'(ow), 32'd0);
    end

    // Dirty set 1, start CLEAR, reset in its 2nd sweep cycle with a request held.
    do_req(0, 1, 0, 4'hF, ow, oi, wt);
    req_valid = 1'b1;
    req_op    = 2'd3;
    step();
    req_op = 2'd2;
    req_set = 2'd1;
    valid_mask = 4'hF;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_clear();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst2_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("rst2_norsp%0d", i), 32'(rsp_valid), 32'd0);
      step();
    end
    check("rst2_ready", 32'(req_ready), 32'd1);
    check("rst2_not_yet_accepted", 32'(rsp_valid), 32'd0);
    m_touch(1, 0);
    step();
    req_valid = 1'b0;
    check("held_accept_valid", 32'(rsp_valid), 32'd1);
    check("held_accept_way", 32'(rsp_way), 32'd0);
    step();
    check("held_accept_once", 32'(rsp_valid), 32'd0);
    do_req(1, 1, 0, 4'hF, ow, oi, wt);
    check("held_alloc_effect", 32'(ow), 32'd2);
    do_req(1, 2, 0, 4'hF, ow, oi, wt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
